// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions: transfer/size/response codes, the RAM slave
// state encoding and the byte-lane decode used by the address phase.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slave_state_e;

  // Little-endian byte lanes touched by a transfer of the given size at the
  // given low address bits. Only meaningful for legal, aligned transfers.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] lanes;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    lanes = 4'b1111;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/ahb_lite_ram_mem.sv
// Word RAM with per-byte write enables: synchronous write, combinational read.
module ahb_lite_ram_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**ADDR_BITS];

  // Commit the enabled byte lanes of the write data at the clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_lite_ram_slave.sv
// AHB-Lite RAM slave: address-phase capture and classification, a five-state
// response FSM with programmable wait states, and transfer/error statistics.
module ahb_lite_ram_slave
  import ahb_lite_pkg::*;
#(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [31:0] XFRCOUNT,
  output logic [31:0] ERRCOUNT
);

  // 33-bit window bounds so a window ending at 2^32 does not overflow.
  localparam logic [32:0] SPAN  = 33'd4 << ADDR_BITS;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  slave_state_e         state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDR_BITS-1:0] addr_q;
  logic [3:0]           be_q;
  logic                 write_q;
  logic [31:0]          xfr_q, err_q;

  logic                 accept;
  logic                 in_range;
  logic                 aligned;
  logic                 addr_ok;
  logic                 mem_we;
  logic                 rd_sel;
  logic                 xfr_inc;
  logic                 err_inc;
  logic [31:0]          mem_rdata;
  logic                 unused_inputs;

  // Burst type and the SEQ/NONSEQ distinction do not change how a beat is served.
  assign unused_inputs = ^{HBURST, HTRANS[0]};

  assign accept   = HREADY && HSEL && HTRANS[1];
  assign in_range = ({1'b0, HADDR} >= {1'b0, BASE_ADDR}) && ({1'b0, HADDR} < LIMIT);

  // Size legality and natural alignment of the incoming address phase.
  always_comb begin
    aligned = 1'b0;
    case (HSIZE)
      HSIZE_BYTE: aligned = 1'b1;
      HSIZE_HALF: aligned = !HADDR[0];
      HSIZE_WORD: aligned = (HADDR[1:0] == 2'b00);
      default:    aligned = 1'b0;
    endcase
  end

  assign addr_ok = in_range && aligned;

  // State register and wait counter; reset drops any transfer in flight.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE, DATA and ERR2 all present HREADY=1 and may accept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        if (accept) begin
          if (!addr_ok) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus response and datapath strobes decoded from the current state.
  always_comb begin
    HREADY  = 1'b1;
    HRESP   = HRESP_OKAY;
    rd_sel  = 1'b0;
    mem_we  = 1'b0;
    xfr_inc = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      ST_WAIT: HREADY = 1'b0;
      ST_DATA: begin
        mem_we  = write_q;
        rd_sel  = !write_q;
        xfr_inc = 1'b1;
      end
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      ST_ERR2: begin
        HRESP   = HRESP_ERROR;
        err_inc = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture the accepted address phase; it stays stable for the whole data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      write_q <= 1'b0;
    end else if (accept) begin
      write_q <= HWRITE;
      addr_q  <= HADDR[ADDR_BITS+1:2];
      be_q    <= byte_lanes(HSIZE, HADDR[1:0]);
    end
  end

  // Completed-transfer statistics, free-running with natural wrap.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      xfr_q <= 32'd0;
      err_q <= 32'd0;
    end else begin
      if (xfr_inc) xfr_q <= xfr_q + 32'd1;
      if (err_inc) err_q <= err_q + 32'd1;
    end
  end

  ahb_lite_ram_mem #(
    .ADDR_BITS(ADDR_BITS)
  ) u_mem (
    .clk_i  (HCLK),
    .addr_i (addr_q),
    .we_i   (mem_we && !HRESET),
    .be_i   (be_q),
    .wdata_i(HWDATA),
    .rdata_o(mem_rdata)
  );

  assign HRDATA   = rd_sel ? mem_rdata : 32'd0;
  assign XFRCOUNT = xfr_q;
  assign ERRCOUNT = err_q;

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
// Bench for ahb_lite_ram_slave: two instances (0 and 2 wait states) share one
// bus driver; a transaction-level model predicts every cycle's response.
`timescale 1ns/1ps
module tb_ahb_lite_ram_slave;

  localparam int AB    = 6;
  localparam int WORDS = 1 << AB;
  localparam logic [31:0] BASE = 32'h0;
  localparam int SPAN  = 4 * WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        hreset, hsel, hwrite;
  int          sel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;

  logic        hsel0, hsel1;
  logic [31:0] hrdata0, hrdata1, xfr0, xfr1, errc0, errc1;
  logic        hready0, hready1, hresp0, hresp1;

  assign hsel0 = hsel && (sel == 0);
  assign hsel1 = hsel && (sel == 1);

  ahb_lite_ram_slave #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0),
    .XFRCOUNT(xfr0), .ERRCOUNT(errc0));

  ahb_lite_ram_slave #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
    .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1),
    .XFRCOUNT(xfr1), .ERRCOUNT(errc1));

  int errors = 0;
  int checks = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance holds at most one transfer in flight: remaining stall
  // cycles, then one completion cycle with HREADY=1.
  logic [31:0] m_mem   [2][WORDS];
  bit          m_known [2][WORDS];
  bit          m_busy [2];
  bit          m_err  [2];
  bit          m_wr   [2];
  int          m_left [2];
  int          m_word [2];
  int          m_off  [2];
  int          m_nbyt [2];
  logic [31:0] m_xfr  [2];
  logic [31:0] m_errc [2];

  function automatic int ws_of(input int k);
    return (k == 0) ? 0 : 2;
  endfunction

  always @(posedge clk) begin
    bit   sk;
    bit   bad;
    int   sz;
    for (int k = 0; k < 2; k++) begin
      sk = hsel && (sel == k);
      if (hreset) begin
        m_busy[k] = 0;
        m_xfr[k]  = 0;
        m_errc[k] = 0;
      end else if (m_busy[k] && m_left[k] > 0) begin
        m_left[k]--;
      end else begin
        if (m_busy[k]) begin
          if (m_err[k]) m_errc[k]++;
          else begin
            if (m_wr[k]) begin
              for (int b = 0; b < 4; b++)
                if (b >= m_off[k] && b < m_off[k] + m_nbyt[k])
                  m_mem[k][m_word[k]][8*b +: 8] = hwdata[8*b +: 8];
              if (m_nbyt[k] == 4) m_known[k][m_word[k]] = 1;
            end
            m_xfr[k]++;
          end
          m_busy[k] = 0;
        end
        if (sk && htrans[1]) begin
          sz  = int'(hsize);
          bad = (haddr < BASE) || (haddr >= BASE + SPAN) || (sz > 2);
          if (!bad) bad = (haddr % (1 << sz)) != 0;
          m_busy[k] = 1;
          m_err[k]  = bad;
          m_wr[k]   = hwrite;
          m_left[k] = bad ? 1 : ws_of(k);
          if (!bad) begin
            m_word[k] = int'((haddr - BASE) >> 2);
            m_off[k]  = int'(haddr[1:0]);
            m_nbyt[k] = 1 << sz;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit          er, ep, known;
    logic [31:0] ed;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        er = 1; ep = 0; ed = 0; known = 1;
        if (m_busy[k]) begin
          if (m_err[k]) begin
            ep = 1; er = (m_left[k] == 0);
          end else if (m_left[k] > 0) begin
            er = 0;
          end else if (!m_wr[k]) begin
            ed = m_mem[k][m_word[k]]; known = m_known[k][m_word[k]];
          end
        end
        if (k == 0) begin
          chk("cyc_hready0", hready0, er);
          chk("cyc_hresp0", hresp0, ep);
          if (known) chk("cyc_hrdata0", hrdata0, ed);
          chk("cyc_xfr0", xfr0, m_xfr[0]);
          chk("cyc_err0", errc0, m_errc[0]);
        end else begin
          chk("cyc_hready1", hready1, er);
          chk("cyc_hresp1", hresp1, ep);
          if (known) chk("cyc_hrdata1", hrdata1, ed);
          chk("cyc_xfr1", xfr1, m_xfr[1]);
          chk("cyc_err1", errc1, m_errc[1]);
        end
      end
    end
  end

  // ---------------- bus driver ----------------
  function automatic logic rdy(input int k);
    return (k == 0) ? hready0 : hready1;
  endfunction

  // One non-pipelined transfer; while the slave stalls, junk address phases
  // are presented to confirm they are ignored.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic rsp,
                      output int waits);
    bit to;
    sel = k; hsel = 1; haddr = a; hwrite = w; hsize = sz; htrans = 2'b10;
    @(posedge clk); #1;
    hwdata = wd; haddr = 32'h0000_0044; hwrite = !w; hsize = 3'b010; htrans = 2'b10;
    waits = 0; to = 1; rd = 0; rsp = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (rdy(k)) begin
        htrans = 2'b00;
        rd  = (k == 0) ? hrdata0 : hrdata1;
        rsp = (k == 0) ? hresp0 : hresp1;
        to  = 0;
        break;
      end
      waits++;
    end
    htrans = 2'b00;
    @(posedge clk); #1;
    chk("xfer_done", to, 0);
  endtask

  logic [31:0] p_addr [16];
  logic        p_wr   [16];
  logic [31:0] p_wd   [16];
  logic [31:0] p_rd   [16];
  int          p_lows;

  // Fully pipelined sequence on the zero-wait instance.
  task automatic pipe(input int n);
    sel = 0; hsel = 1; hsize = 3'b010; p_lows = 0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        haddr = p_addr[i]; hwrite = p_wr[i]; htrans = 2'b10;
      end else htrans = 2'b00;
      if (i > 0) hwdata = p_wd[i-1];
      @(negedge clk);
      if (!hready0) p_lows++;
      if (i > 0) p_rd[i-1] = hrdata0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd, xsave;
  logic        rsp;
  int          w;

  initial begin
    hreset = 1; hsel = 0; sel = 0; htrans = 2'b00; haddr = 0; hwrite = 0;
    hsize = 3'b010; hburst = 3'b000; hwdata = 0;
    repeat (3) @(posedge clk);
    #1 hreset = 0; started = 1;
    @(negedge clk);
    chk("rst_hready", hready1, 1);
    chk("rst_hresp", hresp1, 0);
    chk("rst_hrdata", hrdata1, 0);
    chk("rst_xfr", xfr1, 0);
    chk("rst_err", errc0, 0);
    @(posedge clk); #1;

    // Two wait states: write then read back.
    xfer(1, 32'h10, 1, 3'b010, 32'hDEAD_BEEF, rd, rsp, w);
    chk("ws2_wr_waits", w, 2);
    xfer(1, 32'h10, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("ws2_rd_waits", w, 2);
    chk("ws2_rd_data", rd, 32'hDEAD_BEEF);
    chk("ws2_xfrcount", xfr1, 2);

    // Byte and halfword lane writes.
    xfer(1, 32'h10, 1, 3'b010, 32'h1122_3344, rd, rsp, w);
    xfer(1, 32'h13, 1, 3'b000, 32'hAA00_0000, rd, rsp, w);
    xfer(1, 32'h10, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("byte_lane3", rd, 32'hAA22_3344);
    xfer(1, 32'h10, 1, 3'b001, 32'h0000_5566, rd, rsp, w);
    xfer(1, 32'h10, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("half_lane0", rd, 32'hAA22_5566);

    // Error responses: misaligned word, illegal size, first address past the top.
    xfer(1, 32'h02, 1, 3'b010, 32'h0BAD_0002, rd, rsp, w);
    chk("err_misalign_resp", rsp, 1);
    chk("err_misalign_waits", w, 1);
    xfer(1, 32'h10, 1, 3'b011, 32'h0BAD_0010, rd, rsp, w);
    chk("err_size_resp", rsp, 1);
    xfer(1, BASE + SPAN, 1, 3'b010, 32'hFFFF_FFFF, rd, rsp, w);
    chk("err_range_resp", rsp, 1);
    chk("err_range_waits", w, 1);
    chk("errcount_3", errc1, 3);
    xfer(1, 32'h10, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("err_ram_intact", rd, 32'hAA22_5566);

    // No transfer for IDLE, BUSY or deselected slave.
    xsave = xfr1;
    sel = 1; hsel = 1; haddr = 32'h10; hwrite = 1; hsize = 3'b010; hwdata = 32'h7777_7777;
    htrans = 2'b00; repeat (2) @(posedge clk);
    #1 htrans = 2'b01; repeat (2) @(posedge clk);
    #1 hsel = 0; htrans = 2'b10; repeat (2) @(posedge clk);
    #1 hsel = 1; htrans = 2'b00;
    @(negedge clk);
    chk("idle_xfr_same", xfr1, xsave);
    chk("idle_err_same", errc1, 3);
    chk("idle_hready", hready1, 1);
    @(posedge clk); #1;
    xfer(1, 32'h10, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("idle_ram_intact", rd, 32'hAA22_5566);

    // Highest word in the window is a normal transfer.
    xfer(1, BASE + SPAN - 4, 1, 3'b010, 32'hCAFE_F00D, rd, rsp, w);
    chk("top_wr_resp", rsp, 0);
    xfer(1, BASE + SPAN - 4, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("top_rd_data", rd, 32'hCAFE_F00D);

    // Zero wait states: 8 pipelined writes then 8 pipelined reads.
    for (int i = 0; i < 16; i++) begin
      p_addr[i] = 32'(4 * (i % 8));
      p_wr[i]   = (i < 8);
      p_wd[i]   = (i < 8) ? 32'(4 * i) : 32'h5A5A_5A5A;
    end
    pipe(16);
    chk("pipe_hready_low", p_lows, 0);
    for (int i = 8; i < 16; i++) chk("pipe_rd_data", p_rd[i], 32'(4 * (i - 8)));
    chk("pipe_xfrcount", xfr0, 16);

    // Reset during the wait of a write: the write is dropped.
    xfer(1, 32'h20, 1, 3'b010, 32'h1234_5678, rd, rsp, w);
    sel = 1; hsel = 1; haddr = 32'h20; hwrite = 1; hsize = 3'b010; htrans = 2'b10;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = 32'hBADB_AD00;
    @(negedge clk);
    chk("rstw_in_wait", hready1, 0);
    hreset = 1;
    @(posedge clk); #1;
    hreset = 0;
    @(negedge clk);
    chk("rstw_hready", hready1, 1);
    chk("rstw_hresp", hresp1, 0);
    chk("rstw_xfr", xfr1, 0);
    chk("rstw_err", errc1, 0);
    chk("rstw_xfr0", xfr0, 0);
    @(posedge clk); #1;
    xfer(1, 32'h20, 0, 3'b010, 32'h0, rd, rsp, w);
    chk("rstw_ram_prior", rd, 32'h1234_5678);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
